// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator: op-codes, error codes, engine FSM
// states and the seven-segment glyphs used by the display logic.
package rpn_pkg;

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DUP   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_ARITH     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10
    } state_t;

    // Active-high segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_E     = 7'b111_1001;
    localparam logic [6:0] SEG_R     = 7'b101_0000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b011_1111;
            4'h1: seg = 7'b000_0110;
            4'h2: seg = 7'b101_1011;
            4'h3: seg = 7'b100_1111;
            4'h4: seg = 7'b110_0110;
            4'h5: seg = 7'b110_1101;
            4'h6: seg = 7'b111_1101;
            4'h7: seg = 7'b000_0111;
            4'h8: seg = 7'b111_1111;
            4'h9: seg = 7'b110_1111;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b111_1100;
            4'hC: seg = 7'b011_1001;
            4'hD: seg = 7'b101_1110;
            4'hE: seg = 7'b111_1001;
            default: seg = 7'b111_0001;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Storage for all stack entries below the top-of-stack: one write port and one
// read port with a registered (1-cycle) read, so it maps onto block RAM.
module stack_ram #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    // Contents are deliberately not reset; the engine never reads an entry it has not written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// Stack-and-ALU core of the RPN calculator: top-of-stack in a register, the
// rest of the stack in stack_ram, and a three-state FSM for ops that need NOS.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       op_valid,
    input  logic [2:0]                 op_code,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ready,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic [1:0]                 err
);

    localparam int CW      = $clog2(DEPTH + 1);
    localparam int ENTRIES = DEPTH - 1;
    localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       err_q, err_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] prod_w;

    // NOS lives at count-2; the address is held steady through S_READ so the
    // registered read is valid by S_EXEC.
    assign rd_addr = AW'(count_q - CW'(2));

    assign sum_w  = {1'b0, rd_data} + {1'b0, tos_q};
    assign diff_w = {1'b0, rd_data} - {1'b0, tos_q};
    assign prod_w = (2*WIDTH)'(rd_data) * (2*WIDTH)'(tos_q);

    stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_stack_ram (
        .clk_i     (CLOCK_50),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            op_q    <= OP_PUSH;
            tos_q   <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tos_q   <= tos_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tos_d   = tos_q;
        count_d = count_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = AW'(count_q - CW'(1));
        wr_data = tos_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_PUSH: begin
                            if (count_q == CW'(DEPTH)) begin
                                err_d = ERR_OVERFLOW;
                            end else begin
                                wr_en   = (count_q != '0);
                                tos_d   = data_in;
                                count_d = count_q + CW'(1);
                            end
                        end
                        OP_DUP: begin
                            if (count_q == '0) begin
                                err_d = ERR_UNDERFLOW;
                            end else if (count_q == CW'(DEPTH)) begin
                                err_d = ERR_OVERFLOW;
                            end else begin
                                wr_en   = 1'b1;
                                count_d = count_q + CW'(1);
                            end
                        end
                        OP_POP: begin
                            if (count_q == '0) begin
                                err_d = ERR_UNDERFLOW;
                            end else if (count_q == CW'(1)) begin
                                tos_d   = '0;
                                count_d = '0;
                            end else begin
                                op_d    = op_code;
                                state_d = S_READ;
                            end
                        end
                        OP_CLEAR: begin
                            tos_d   = '0;
                            count_d = '0;
                            err_d   = ERR_NONE;
                        end
                        default: begin
                            // ADD, SUB, MUL, SWAP all need two operands.
                            if (count_q < CW'(2)) begin
                                err_d = ERR_UNDERFLOW;
                            end else begin
                                op_d    = op_code;
                                state_d = S_READ;
                            end
                        end
                    endcase
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_POP: begin
                        tos_d   = rd_data;
                        count_d = count_q - CW'(1);
                    end
                    OP_ADD: begin
                        tos_d   = sum_w[WIDTH-1:0];
                        count_d = count_q - CW'(1);
                        if (sum_w[WIDTH]) err_d = ERR_ARITH;
                    end
                    OP_SUB: begin
                        tos_d   = diff_w[WIDTH-1:0];
                        count_d = count_q - CW'(1);
                        if (diff_w[WIDTH]) err_d = ERR_ARITH;
                    end
                    OP_MUL: begin
                        tos_d   = prod_w[WIDTH-1:0];
                        count_d = count_q - CW'(1);
                        if (|prod_w[2*WIDTH-1:WIDTH]) err_d = ERR_ARITH;
                    end
                    OP_SWAP: begin
                        wr_en   = 1'b1;
                        wr_addr = rd_addr;
                        tos_d   = rd_data;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign top   = tos_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign err   = err_q;

endmodule

// File: doc/rpn_stack_engine.md
# rpn_stack_engine

- Parametrised stack-and-ALU core for the RPN calculator.
- Keeps the top of stack in a register and the rest of the stack in a synchronous RAM, with a small FSM.
- Supports push, pop, arithmetic, DUP, SWAP and CLEAR, and flags stack and arithmetic errors.
- Sits between the switch/key input decoder (upstream) and the seven-segment/LED display logic (downstream), which shows `top`, `count` and "Err".

## Interface
Parameters:
- `WIDTH`, default 8: data word width; must be ≥ 2.
- `DEPTH`, default 16: maximum number of stack entries; must be ≥ 2. The RAM holds `DEPTH-1` entries.

Ports:
- `CLOCK_50`  in  1: the single clock; all state changes on its rising edge.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `op_valid`  in  1: an operation is presented this cycle.
- `op_code`  in  3: PUSH=000, POP=001, ADD=010, SUB=011, MUL=100, DUP=101, SWAP=110, CLEAR=111.
- `data_in`  in  WIDTH: operand for PUSH; ignored for all other ops.
- `ready`  out  1: the engine can accept an operation this cycle.
- `top`  out  WIDTH: top-of-stack value; 0 when the stack is empty.
- `count`  out  $clog2(DEPTH+1): number of stack entries.
- `empty`, `full`  out  1 each: `count==0` and `count==DEPTH` respectively.
- `err`  out  2: sticky error code. NONE=00, UNDERFLOW=01, OVERFLOW=10, ARITH=11.

## Operation
- **Accept rule:** an op is accepted when `op_valid && ready` at a clock edge. If `op_valid` is high while `ready` is low, the op is ignored (there is no queue).
- **Storage layout:** TOS is held in a register. Entry `count-2` of the RAM is the next-on-stack (NOS). The RAM has a synchronous write and a synchronous read with 1-cycle latency.
- **FSM states:**
  - S_IDLE: `ready=1`.
  - S_READ: RAM address is `count-2`.
  - S_EXEC: compute and update.
  - Transitions: S_IDLE→S_READ when an op that needs NOS is accepted; S_READ→S_EXEC; S_EXEC→S_IDLE.
- **Single-cycle ops** (complete at the accepting edge; the engine stays in S_IDLE):
  - PUSH: if `count>0`, write TOS to `mem[count-1]`; then TOS=`data_in` and `count++`.
  - DUP: write TOS to `mem[count-1]`; `count++`.
  - CLEAR: `count=0`, `top=0`, `err=NONE`. CLEAR is the only op that clears `err`.
- **NOS ops** (POP, ADD, SUB, MUL, SWAP):
  - POP with `count==1` is single-cycle: TOS=0, `count=0`.
  - POP with `count≥2`: TOS=NOS, `count--`.
  - ADD: TOS=NOS+TOS. SUB: TOS=NOS−TOS. MUL: TOS=low WIDTH bits of NOS×TOS. Each of these does `count--`.
  - SWAP: write TOS to `mem[count-2]`, then TOS=NOS. `count` is unchanged.
- **Arithmetic:** unsigned, truncated to WIDTH bits.
  - A carry out (ADD), a borrow (SUB) or any nonzero high half (MUL) sets `err=ARITH`.
  - The truncated result is still written.
- **Stack errors** (checked at accept; all single-cycle):
  - UNDERFLOW: POP, DUP or SWAP with `count==0`; ADD, SUB, MUL or SWAP with `count<2`.
  - OVERFLOW: PUSH or DUP with `count==DEPTH`.
  - On a stack error the stack is left unchanged and `err` is set.
- **Sticky `err`:** `err` holds until CLEAR or reset. A later error overwrites the code with the newest one.
- **Reset:** reset asserted at any time (including in S_READ or S_EXEC) aborts the current op immediately and returns to S_IDLE. RAM contents are not reset and are don't-care.

## Timing
- **Reset values:** `ready=1`, `top=0`, `count=0`, `empty=1`, `full=0`, `err=00`, state S_IDLE.
- **Single-cycle ops:** accepted at edge E0; outputs are updated after E0; `ready` stays high.
- **NOS ops:**
  - Accepted at edge E0.
  - `ready=0` from E0 to E2 (two cycles).
  - `top`, `count` and `err` update at E2.
  - `ready=1` after E2, so the next op can be accepted at E3.
- **Output timing:** all outputs are registered or decoded from registers. There is no combinational path from the inputs to the outputs.

## Structure
- **Package `rpn_pkg`:** op-code constants, error codes, FSM state encodings, and the shared seven-segment constants. The calculator top level imports them from here.
- **Sub-module `stack_ram`:**
  - Parameters: WIDTH, `DEPTH-1` entries.
  - One write port and one synchronous read port.
  - Inferable as on-chip block RAM.
- **Top level of this block:** FSM, TOS register, count register, ALU and error logic.

## Test plan
All scenarios use `WIDTH=8`, `DEPTH=4`.
- **ADD latency:** reset; PUSH 5; PUSH 3; ADD → `top=8`, `count=1`, `err=00`, `ready` low for exactly 2 cycles.
- **SUB borrow:** PUSH 3; PUSH 5; SUB → `top=0xFE`, `count=1`, `err=ARITH`; then CLEAR → `err=00`, `empty=1`.
- **Full / overflow:** 4 PUSHes of 1, 2, 3, 4 → `full=1`, `top=4`. A 5th PUSH of 9 → `err=OVERFLOW`, `top=4`, `count=4`. Then POP×3 → `top=1`, `count=1`.
- **Underflow:** after reset, POP → `err=UNDERFLOW`, `count=0`. Then PUSH 6; ADD → `err` stays UNDERFLOW, `top=6`, `count=1`.
- **SWAP / DUP / MUL:**
  - PUSH 7; PUSH 9; SWAP → `top=7`; POP → `top=9`, `count=1`.
  - PUSH 20; DUP; MUL → `top=0x90`, `err=ARITH`.
- **Ignore while busy, reset mid-op:**
  - `op_valid`=PUSH 1 held during the ADD busy cycles → ignored; `count` is as if the PUSH never occurred.
  - `RESET_N` low during S_READ → all outputs take their reset values immediately.
